// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants, instruction formats and the FIFO entry type.
`default_nettype none
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FLW    = 7'b0000111;
  localparam logic [6:0] OP_FSW    = 7'b0100111;

  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL
  } instr_fmt_e;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } enc_entry_t;

  // True when v is the sign extension of its low 'bits' bits.
  function automatic logic fits_signed(input logic [31:0] v, input int bits);
    logic signed [31:0] hi;
    hi = $signed(v) >>> (bits - 1);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
// Synchronous FIFO of generic entries; head reads as zero while empty.
`default_nettype none
module sync_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [31:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  T     wdata,
  output logic full,
  input  logic pop,
  output logic empty,
  output T     rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = empty ? '0 : mem[rptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
// RV32I instruction encoder with immediate range checks and an output FIFO.
// Define INSTR_ENCODER_FP_EN to encode FLW/FSW; otherwise they are illegal.
`default_nettype none
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [6:0]       i_opcode,
  input  logic [4:0]       i_rd,
  input  logic [2:0]       i_funct3,
  input  logic [4:0]       i_rs1,
  input  logic [4:0]       i_rs2,
  input  logic [6:0]       i_funct7,
  input  logic [31:0]      i_imm,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_instr,
  output logic             o_err,
  output logic [CNT_W-1:0] o_instr_cnt,
  output logic [CNT_W-1:0] o_err_cnt
);

  instr_fmt_e fmt;
  logic [31:0] enc_word;
  logic        enc_err;
  enc_entry_t  in_entry;
  enc_entry_t  head;
  logic        full;
  logic        empty;
  logic        accept;

  always_comb begin
    fmt = FMT_ILL;
    case (i_opcode)
      OP_R:              fmt = FMT_R;
      OP_IMM:            fmt = (i_funct3 == F3_SLL || i_funct3 == F3_SRL_SRA) ? FMT_SH : FMT_I;
      OP_LOAD, OP_JALR:  fmt = FMT_I;
      OP_STORE:          fmt = FMT_S;
      OP_BRANCH:         fmt = FMT_B;
      OP_JAL:            fmt = FMT_J;
      OP_LUI, OP_AUIPC:  fmt = FMT_U;
`ifdef INSTR_ENCODER_FP_EN
      OP_FLW:            fmt = FMT_I;
      OP_FSW:            fmt = FMT_S;
`endif
      default:           fmt = FMT_ILL;
    endcase
  end

  // Out-of-range immediates are still packed by truncation and flagged.
  always_comb begin
    enc_word = NOP;
    enc_err  = 1'b0;
    case (fmt)
      FMT_R: begin
        enc_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      end
      FMT_SH: begin
        enc_word = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, i_opcode};
        enc_err  = (i_imm[31:5] != '0);
      end
      FMT_I: begin
        enc_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        enc_err  = !fits_signed(i_imm, 12);
      end
      FMT_S: begin
        enc_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        enc_err  = !fits_signed(i_imm, 12);
      end
      FMT_B: begin
        enc_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                    i_imm[4:1], i_imm[11], i_opcode};
        enc_err  = !fits_signed(i_imm, 13) || i_imm[0];
      end
      FMT_J: begin
        enc_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
        enc_err  = !fits_signed(i_imm, 21) || i_imm[0];
      end
      FMT_U: begin
        enc_word = {i_imm[31:12], i_rd, i_opcode};
        enc_err  = (i_imm[11:0] != '0);
      end
      default: begin
        enc_word = NOP;
        enc_err  = 1'b1;
      end
    endcase
  end

  assign in_entry = '{instr: enc_word, err: enc_err};
  assign o_ready  = !full;
  assign accept   = i_valid && o_ready && !i_flush;

  sync_fifo #(
    .DEPTH (DEPTH),
    .T     (enc_entry_t)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .flush (i_flush),
    .push  (accept),
    .wdata (in_entry),
    .full  (full),
    .pop   (i_ready),
    .empty (empty),
    .rdata (head)
  );

  assign o_valid = !empty;
  assign o_instr = head.instr;
  assign o_err   = head.err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_instr_cnt <= '0;
      o_err_cnt   <= '0;
    end else if (accept) begin
      if (o_instr_cnt != '1) o_instr_cnt <= o_instr_cnt + CNT_W'(1);
      if (enc_err && o_err_cnt != '1) o_err_cnt <= o_err_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
// Randomised and directed bench for instr_encoder against a queue-based reference model.
`default_nettype none
module tb_instr_encoder;

  localparam int DEPTH = 2;
  localparam int CNT_W = 16;
`ifdef INSTR_ENCODER_FP_EN
  localparam bit FP_EN = 1'b1;
`else
  localparam bit FP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, flush, valid, ready_out, rdy_in;
  logic [6:0]       opcode, funct7;
  logic [4:0]       rd, rs1, rs2;
  logic [2:0]       funct3;
  logic [31:0]      imm;
  logic             vld_out, err_out;
  logic [31:0]      instr_out;
  logic [CNT_W-1:0] instr_cnt, err_cnt;

  instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(ready_out),
    .i_opcode(opcode), .i_rd(rd), .i_funct3(funct3), .i_rs1(rs1), .i_rs2(rs2),
    .i_funct7(funct7), .i_imm(imm), .o_valid(vld_out), .i_ready(rdy_in),
    .o_instr(instr_out), .o_err(err_out), .o_instr_cnt(instr_cnt), .o_err_cnt(err_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [32:0]      q[$];
  logic [CNT_W-1:0] m_icnt, m_ecnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, expv);
  endtask

  // Reference: field placement and range limits taken straight from the ISA rules.
  function automatic logic [32:0] ref_encode(input logic [6:0] op, input logic [4:0] d,
      input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2,
      input logic [6:0] f7, input logic [31:0] v);
    int s;
    logic [31:0] w;
    logic e;
    s = v;
    if (op == 7'h33) begin
      w = {f7, s2, s1, f3, d, op}; e = 1'b0;
    end else if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
      w = {f7, v[4:0], s1, f3, d, op}; e = (v > 32'd31);
    end else if (op == 7'h13 || op == 7'h03 || op == 7'h67 || (FP_EN && op == 7'h07)) begin
      w = {v[11:0], s1, f3, d, op}; e = (s < -2048) || (s > 2047);
    end else if (op == 7'h23 || (FP_EN && op == 7'h27)) begin
      w = {v[11:5], s2, s1, f3, v[4:0], op}; e = (s < -2048) || (s > 2047);
    end else if (op == 7'h63) begin
      w = {v[12], v[10:5], s2, s1, f3, v[4:1], v[11], op};
      e = (s < -4096) || (s > 4095) || (s % 2 != 0);
    end else if (op == 7'h6F) begin
      w = {v[20], v[10:1], v[11], v[19:12], d, op};
      e = (s < -1048576) || (s > 1048575) || (s % 2 != 0);
    end else if (op == 7'h37 || op == 7'h17) begin
      w = (v & 32'hFFFF_F000) | {20'd0, d, op}; e = ((v & 32'hFFF) != 0);
    end else begin
      w = 32'h0000_0013; e = 1'b1;
    end
    return {e, w};
  endfunction

  task automatic compare_model();
    check("valid", 32'(vld_out), 32'(q.size() != 0));
    check("instr", instr_out, (q.size() != 0) ? q[0][31:0] : 32'd0);
    check("err",   32'(err_out), (q.size() != 0) ? 32'(q[0][32]) : 32'd0);
    check("ready", 32'(ready_out), 32'(q.size() < DEPTH));
    check("icnt",  32'(instr_cnt), 32'(m_icnt));
    check("ecnt",  32'(err_cnt), 32'(m_ecnt));
  endtask

  task automatic model_edge();
    logic [32:0] e;
    bit can_take;
    can_take = (q.size() < DEPTH);
    if (flush) q.delete();
    else begin
      if (q.size() != 0 && rdy_in) void'(q.pop_front());
      if (valid && can_take) begin
        e = ref_encode(opcode, rd, funct3, rs1, rs2, funct7, imm);
        q.push_back(e);
        if (m_icnt != '1) m_icnt++;
        if (e[32] && m_ecnt != '1) m_ecnt++;
      end
    end
  endtask

  task automatic set_req(input logic [6:0] op, input logic [4:0] d, input logic [2:0] f3,
      input logic [4:0] s1, input logic [4:0] s2, input logic [6:0] f7, input logic [31:0] v);
    opcode = op; rd = d; funct3 = f3; rs1 = s1; rs2 = s2; funct7 = f7; imm = v;
  endtask

  // Starts and ends on a falling edge; outputs are checked after every rising edge.
  task automatic step(input logic v, input logic r, input logic f);
    valid = v; rdy_in = r; flush = f;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 8) begin
      step(1'b0, 1'b1, 1'b0);
      k++;
    end
    step(1'b0, 1'b1, 1'b0);
    check("drain_empty", 32'(vld_out), 32'd0);
  endtask

  task automatic encode_one(input string tag, input logic [31:0] w, input logic e);
    drain();
    step(1'b1, 1'b0, 1'b0);
    check(tag, instr_out, w);
    check({tag, "_err"}, 32'(err_out), 32'(e));
  endtask

  function automatic logic [31:0] pick_imm();
    logic [31:0] tbl [14];
    tbl = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094, 32'd4095, -32'sd4096,
            -32'sd4098, 32'hFFFF_F000, 32'd31, 32'd32, 32'd1048574, -32'sd1048576, 32'd1048576};
    case ($urandom_range(0, 5))
      0: return $urandom;
      1: return $urandom_range(0, 63) - 32;
      2: return tbl[$urandom_range(0, 13)];
      3: return $urandom & 32'hFFFF_F000;
      4: return ($urandom_range(0, 5000) - 2500) * 2;
      default: return $urandom_range(0, 2000000) - 1000000;
    endcase
  endfunction

  initial begin
    logic [6:0] ops [12];
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h07, 7'h27, 7'h5B};

    rst = 1'b1; flush = 1'b0; valid = 1'b0; rdy_in = 1'b0;
    set_req(7'h0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
    q.delete(); m_icnt = '0; m_ecnt = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(vld_out), 32'd0);
    check("rst_instr", instr_out, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(ready_out), 32'd1);
    check("rst_icnt", 32'(instr_cnt), 32'd0);
    @(negedge clk);

    set_req(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFF);
    encode_one("addi_m1", 32'hFFF0_0093, 1'b0);
    set_req(7'h23, 5'd0, 3'b010, 5'd1, 5'd2, 7'd0, -32'sd4);
    encode_one("sw", 32'hFE20_AE23, 1'b0);
    set_req(7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd8);
    encode_one("beq", 32'h0000_0463, 1'b0);
    set_req(7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);
    encode_one("jal_2048", 32'h0010_00EF, 1'b0);
    set_req(7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd3);
    encode_one("jal_odd", 32'h0020_00EF, 1'b1);
    check("errcnt_1", 32'(err_cnt), 32'd1);
    set_req(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);
    encode_one("addi_2048", 32'h8000_0093, 1'b1);
    check("errcnt_2", 32'(err_cnt), 32'd2);
    set_req(7'h07, 5'd3, 3'b010, 5'd2, 5'd0, 7'd0, 32'd4);
    if (FP_EN) encode_one("flw", 32'h0041_2187, 1'b0);
    else       encode_one("flw_ill", 32'h0000_0013, 1'b1);
    drain();

    // Asynchronous reset while words are queued.
    set_req(7'h13, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'd7);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(vld_out), 32'd0);
    check("arst_instr", instr_out, 32'd0);
    check("arst_err", 32'(err_out), 32'd0);
    check("arst_icnt", 32'(instr_cnt), 32'd0);
    check("arst_ecnt", 32'(err_cnt), 32'd0);
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q.delete(); m_icnt = '0; m_ecnt = '0;

    // Backpressure: third word waits until space frees while full.
    for (int w = 0; w < 3; w++) begin
      set_req(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'(w + 1));
      step(1'b1, 1'b0, 1'b0);
    end
    check("bp_ready", 32'(ready_out), 32'd0);
    check("bp_head0", instr_out, 32'h0010_0093);
    step(1'b1, 1'b1, 1'b0);
    check("bp_head1", instr_out, 32'h0020_0093);
    step(1'b1, 1'b1, 1'b0);
    check("bp_head2", instr_out, 32'h0030_0093);
    step(1'b0, 1'b1, 1'b0);
    check("bp_empty", 32'(vld_out), 32'd0);
    check("bp_icnt", 32'(instr_cnt), 32'd3);

    // Flush beats a simultaneous push on a full FIFO.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("fl_full", 32'(ready_out), 32'd0);
    step(1'b1, 1'b0, 1'b1);
    check("fl_valid", 32'(vld_out), 32'd0);
    check("fl_icnt", 32'(instr_cnt), 32'd5);
    step(1'b0, 1'b1, 1'b0);

    for (int c = 0; c < 600; c++) begin
      set_req(ops[$urandom_range(0, 11)], 5'($urandom), 3'($urandom), 5'($urandom),
              5'($urandom), 7'($urandom), pick_imm());
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the decode-side immediate generator: takes an opcode, register/funct fields and a full 32-bit signed immediate, and packs them into a 32-bit RV32I instruction word.
- Checks that the immediate is representable in the target format and flags range/alignment errors.
- Buffers encoded words in a small FIFO behind valid/ready handshakes.
- Sits between the debug/boot instruction injector and the instruction-memory write port.

Parameters:
- DEPTH, 2, output FIFO entries (power of two, ≥2).
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_flush  input  1  synchronous FIFO clear.
- i_valid  input  1  request valid.
- o_ready  output  1  encoder can accept.
- i_opcode  input  7  instruction opcode.
- i_rd  input  5  destination register.
- i_funct3  input  3  funct3.
- i_rs1  input  5  source register 1.
- i_rs2  input  5  source register 2.
- i_funct7  input  7  funct7; used for R-type and shifts.
- i_imm  input  32  signed byte immediate; for U-type, the full value.
- o_valid  output  1  encoded word available.
- i_ready  input  1  consumer accepts.
- o_instr  output  32  encoded instruction word.
- o_err  output  1  error flag travelling with o_instr.
- o_instr_cnt  output  CNT_W  words accepted, saturating.
- o_err_cnt  output  CNT_W  errored words accepted, saturating.

Behaviour:
- Reset (async, i_rst=1): FIFO emptied; o_valid=0, o_instr=0, o_err=0, both counters 0; o_ready=1 once reset is released.
- Accept on i_valid&&o_ready at rising edge.
- o_ready = (count<DEPTH). It does not depend on i_ready, so a full FIFO refuses input even while popping.
- Pop on o_valid&&i_ready.
- Latency: a word accepted at edge N is visible on o_instr with o_valid=1 from edge N onward (1 cycle).
- Ordering is strict FIFO. Push and pop in the same cycle leaves count unchanged. Pointers wrap modulo DEPTH.
- o_instr/o_err show the head entry; they hold 0 when empty.
- i_flush: empties the FIFO next edge and has priority over a simultaneous push; that request counts as not accepted. Counters are not cleared.
- Encoding by opcode:
  - OP 0110011: funct7|rs2|rs1|funct3|rd|op; i_imm ignored; never errors.
  - OP-IMM 0010011, funct3 001/101 (shifts): [31:25]=i_funct7, [24:20]=imm[4:0]. Error if imm[31:5]≠0.
  - OP-IMM other funct3, LOAD 0000011, JALR 1100111: [31:20]=imm[11:0]. Error if imm not a sign-extension of imm[11:0].
  - STORE 0100011: [31:25]=imm[11:5], [11:7]=imm[4:0]. Range rule as for I-type.
  - BRANCH 1100011: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]. Error if not 13-bit signed or imm[0]=1.
  - JAL 1101111: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12], rd. Error if not 21-bit signed or imm[0]=1.
  - LUI 0110111, AUIPC 0010111: [31:12]=imm[31:12], rd. Error if imm[11:0]≠0.
  - Any other opcode: word=32'h0000_0013 (NOP), error=1.
- An errored word is still encoded by truncation and enqueued with o_err=1. It is never dropped.
- o_instr_cnt increments on every accept. o_err_cnt increments on errored accepts. Both saturate at all-ones.

Optional Feature:
- INSTR_ENCODER_FP_EN defined: FLW 0000111 is encoded as I-type and FSW 0100111 as S-type, with the same range rules.
- Undefined: both opcodes fall into the illegal path (NOP, o_err=1).

Decomposition:
- Shared package riscv_pkg:
  - opcode constants, including FLW/FSW;
  - shift funct3 constants;
  - NOP constant;
  - typedef instr_fmt_e {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL};
  - packed struct enc_entry_t {instr, err}.
- Sub-module sync_fifo, parameterised on DEPTH and the entry type, holds the buffer. The encode/check logic stays combinational in the top.

Test Plan:
- addi x1,x0,-1 (op 0010011, rd=1, f3=0, imm=32'hFFFF_FFFF) → o_instr=32'hFFF0_0093, o_err=0, o_valid one edge after accept.
- sw x2,-4(x1) (imm=-4, rs1=1, rs2=2, f3=010) → 32'hFE20_AE23. beq x0,x0,+8 → 32'h0000_0463.
- jal x1,+2048 → 32'h0010_00EF, o_err=0. jal imm=3 → o_err=1, o_err_cnt=1. addi imm=2048 → o_err=1, o_err_cnt=2.
- Backpressure: hold i_ready=0 and offer 3 words. Two are accepted, o_ready=0, the third is held. Release i_ready: all three emerge in order and o_instr_cnt=3.
- Assert i_flush with a full FIFO plus a simultaneous push → next cycle o_valid=0 and count 0. Assert i_rst mid-stream → all outputs 0 immediately.
- FLW (op 0000111, imm=4, rs1=2, rd=3, f3=010): with INSTR_ENCODER_FP_EN → 32'h0041_2187, o_err=0. Without it → 32'h0000_0013, o_err=1.
